// File: rtl/bus_demux_rx_pkg.sv
// bus_demux_rx shared definitions.
// Defaults, lane encodings and pointer-width helper.
package bus_demux_rx_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  localparam logic LANE_A = 1'b1;
  localparam logic LANE_B = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_demux_rx_lane_fifo.sv
// Per-lane FIFO with registered head.
// Occupancy is one bit wider than the pointers.
module lane_fifo
  import bus_demux_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == (PTR_W+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/bus_demux_rx.sv
// Shared-bus receiver: steers words into two lane FIFOs
// and counts words delivered per lane.
module bus_demux_rx
  import bus_demux_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_sel,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  logic full_a, full_b;
  logic empty_a, empty_b;
  logic push_a, push_b;
  logic pop_a, pop_b;

  // Ready looks only at registered occupancy, never at same-cycle pops.
  assign bus_ready = (bus_sel == LANE_A) ? ~full_a : ~full_b;
  assign push_a    = bus_valid & bus_ready & (bus_sel == LANE_A);
  assign push_b    = bus_valid & bus_ready & (bus_sel == LANE_B);

  assign a_valid = ~empty_a;
  assign b_valid = ~empty_b;
  assign pop_a   = a_valid & a_ready;
  assign pop_b   = b_valid & b_ready;

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .wdata (bus_data),
    .full  (full_a),
    .pop   (pop_a),
    .empty (empty_a),
    .head  (a_data)
  );

  lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .wdata (bus_data),
    .full  (full_b),
    .pop   (pop_b),
    .empty (empty_b),
    .head  (b_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (pop_a) a_cnt <= a_cnt + CNT_W'(1);
      if (pop_b) b_cnt <= b_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_demux_rx.sv
// Scoreboard bench for bus_demux_rx.
// Driver queues expected words; a negedge monitor checks deliveries.
module tb_bus_demux_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bus_data;
  logic       bus_sel;
  logic       bus_valid;
  logic       bus_ready;
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int mdl_a = 0;
  int mdl_b = 0;

  bus_demux_rx dut (
    .clk       (clk),
    .rst       (rst),
    .bus_data  (bus_data),
    .bus_sel   (bus_sel),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .a_cnt     (a_cnt),
    .b_cnt     (b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each presented head against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      mdl_a = 0;
      mdl_b = 0;
    end else begin
      chk("a_cnt", int'(a_cnt), mdl_a % 256);
      chk("b_cnt", int'(b_cnt), mdl_b % 256);
      if (a_valid) begin
        if (qa.size() == 0) chk("a_spurious", 1, 0);
        else begin
          chk("a_data", int'(a_data), int'(qa[0]));
          if (a_ready) begin
            void'(qa.pop_front());
            mdl_a++;
          end
        end
      end
      if (b_valid) begin
        if (qb.size() == 0) chk("b_spurious", 1, 0);
        else begin
          chk("b_data", int'(b_data), int'(qb[0]));
          if (b_ready) begin
            void'(qb.pop_front());
            mdl_b++;
          end
        end
      end
    end
  end

  // Drive one word; returns at posedge+1 after it is accepted.
  task automatic push_word(input logic sel, input logic [3:0] d);
    bit ok;
    ok = 0;
    bus_sel   = sel;
    bus_data  = d;
    bus_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 0, 1);
    else if (sel) qa.push_back(d);
    else qb.push_back(d);
    @(posedge clk);
    #1 bus_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus_data = '0;
    bus_sel = 1'b1;
    bus_valid = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // reset state
    chk("rst_a_valid", int'(a_valid), 0);
    chk("rst_b_valid", int'(b_valid), 0);
    chk("rst_a_data", int'(a_data), 0);
    chk("rst_b_data", int'(b_data), 0);
    chk("rst_a_cnt", int'(a_cnt), 0);
    chk("rst_b_cnt", int'(b_cnt), 0);
    bus_sel = 1'b1; #1;
    chk("rst_ready_a", int'(bus_ready), 1);
    bus_sel = 1'b0; #1;
    chk("rst_ready_b", int'(bus_ready), 1);

    // fill lane A, hold head
    push_word(1'b1, 4'b1011);
    push_word(1'b1, 4'b1001);
    bus_sel = 1'b1; #1;
    chk("full_ready_a", int'(bus_ready), 0);
    bus_sel = 1'b0; #1;
    chk("full_ready_b", int'(bus_ready), 1);
    chk("hold_a_valid", int'(a_valid), 1);
    chk("hold_a_data", int'(a_data), 4'b1011);
    cycles(1);
    chk("hold_a_data2", int'(a_data), 4'b1011);
    a_ready = 1'b1;
    cycles(2);
    a_ready = 1'b0;
    chk("drain_a_cnt", int'(a_cnt), 2);
    chk("drain_a_valid", int'(a_valid), 0);

    // lane B latency
    b_ready = 1'b1;
    push_word(1'b0, 4'b1110);
    chk("lat_b_valid", int'(b_valid), 1);
    chk("lat_b_data", int'(b_data), 4'b1110);
    chk("lat_b_cnt0", int'(b_cnt), 0);
    cycles(1);
    chk("lat_b_valid2", int'(b_valid), 0);
    chk("lat_b_cnt1", int'(b_cnt), 1);

    // full-lane stall while popping
    push_word(1'b1, 4'b0011);
    push_word(1'b1, 4'b0110);
    bus_sel = 1'b1;
    bus_data = 4'b1000;
    bus_valid = 1'b1;
    a_ready = 1'b1;
    #1;
    chk("stall_ready", int'(bus_ready), 0);
    @(negedge clk);
    cycles(1);
    chk("stall_ready_next", int'(bus_ready), 1);
    qa.push_back(4'b1000);
    cycles(1);
    bus_valid = 1'b0;
    cycles(3);
    a_ready = 1'b0;
    chk("stall_a_cnt", int'(a_cnt), 5);
    chk("stall_a_valid", int'(a_valid), 0);

    // 256-word stream to lane B, counter wrap
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    b_ready = 1'b1;
    for (int i = 0; i < 256; i++)
      push_word(1'b0, 4'(i * 7 + 3));
    cycles(3);
    chk("wrap_b_cnt", int'(b_cnt), 0);
    chk("wrap_b_valid", int'(b_valid), 0);

    // reset discards stored words
    a_ready = 1'b0;
    push_word(1'b1, 4'b1100);
    push_word(1'b1, 4'b0010);
    chk("pre_rst_a_valid", int'(a_valid), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("post_rst_a_valid", int'(a_valid), 0);
    chk("post_rst_a_cnt", int'(a_cnt), 0);
    chk("post_rst_a_data", int'(a_data), 0);
    push_word(1'b1, 4'b0101);
    chk("sole_a_data", int'(a_data), 4'b0101);
    a_ready = 1'b1;
    cycles(1);
    chk("sole_a_valid", int'(a_valid), 0);
    chk("sole_a_cnt", int'(a_cnt), 1);
    a_ready = 1'b0;
    b_ready = 1'b0;
    cycles(2);

    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_demux_rx.md
Name: bus_demux_rx

Overview:
- Receive side of the shared 4-bit bus.
- The upstream bus driver places one word per transfer on bus_data, with bus_sel tagging the source lane: 1 = lane A, 0 = lane B.
- This block accepts each word with a valid/ready handshake, steers it into a small per-lane FIFO, and presents the two lanes as independent valid/ready streams.
- It also maintains a wrap-around count of words delivered per lane.

Parameters:
- WIDTH, 4: bus and lane data width in bits.
- DEPTH, 2: entries per lane FIFO; must be a power of two, at least 2.
- CNT_W, 8: width of the per-lane delivered-word counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_data  input  WIDTH  word on the shared bus.
- bus_sel  input  1  lane tag: 1 = lane A, 0 = lane B.
- bus_valid  input  1  bus_data/bus_sel are valid this cycle.
- bus_ready  output  1  the addressed lane FIFO can accept a word this cycle.
- a_data  output  WIDTH  head of lane A FIFO.
- a_valid  output  1  lane A FIFO non-empty.
- a_ready  input  1  lane A consumer accepts the head.
- b_data  output  WIDTH  head of lane B FIFO.
- b_valid  output  1  lane B FIFO non-empty.
- b_ready  input  1  lane B consumer accepts the head.
- a_cnt  output  CNT_W  lane A words delivered (a_valid & a_ready), modulo 2^CNT_W.
- b_cnt  output  CNT_W  lane B words delivered, modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Lane FIFOs empty; read/write pointers and occupancy cleared.
  - a_valid=0, b_valid=0, a_data=0, b_data=0, a_cnt=0, b_cnt=0.
  - bus_ready=1 once rst is deasserted.
  - Reset mid-transfer discards all stored words; no handshake completes in a cycle where rst=1.
- Push:
  - bus_ready = (bus_sel ? !fullA : !fullB), combinational from bus_sel and registered occupancy.
  - A push occurs when bus_valid & bus_ready; the word is written to the lane selected by bus_sel.
- Pop:
  - Lane X pops when X_valid & X_ready.
  - X_data is the registered head; it must not change while X_valid=1 and X_ready=0.
- Latency: a word pushed into an empty lane at edge N is visible at X_valid/X_data after edge N (1 cycle). There is no combinational bus-to-lane bypass.
- Full boundary:
  - bus_ready for a full lane stays 0 even if that lane pops in the same cycle; ready depends only on registered occupancy.
  - A word tagged for a full lane stalls the bus. The other lane still drains.
- Empty boundary: a pop on an empty lane cannot occur (X_valid=0); the counter and pointers are unchanged.
- Simultaneous push and pop on the same non-full, non-empty lane: occupancy unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits; full = (occ==DEPTH).
- Counters increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
- Lanes are fully independent apart from the shared bus_ready.
- There is no ordering guarantee across lanes.

Decomposition:
- Shared package holds:
  - WIDTH/DEPTH/CNT_W defaults.
  - Lane encoding constants LANE_A=1'b1, LANE_B=1'b0.
  - A clog2 function for pointer widths.
- One natural sub-module, lane_fifo:
  - Parameterised WIDTH/DEPTH; push/full/pop/empty/head ports; synchronous active-high reset.
  - Instantiated twice.
- Counters and steering live in the top level.

Test Plan:
- Reset then idle -> a_valid=b_valid=0, a_cnt=b_cnt=0, bus_ready=1 for either bus_sel.
- Push 4'b1011 sel=1, then 4'b1001 sel=1, a_ready=0 -> a_valid=1 with a_data=1011 held; after the second push bus_ready=0 for sel=1 and =1 for sel=0. Then a_ready=1 for 2 cycles -> a_data 1011 then 1001, a_cnt=2.
- Push 4'b1110 sel=0 with b_ready=1 held -> b_valid rises 1 cycle after the push, b_data=1110, b_cnt increments 1 cycle after b_valid.
- Lane A full, bus_valid=1 sel=1 data=4'b1000, a_ready=1 -> no push that cycle; the word is accepted on the next cycle; no loss or duplication.
- Stream 256 words to lane B with b_ready=1 -> b_cnt wraps to 0; data order matches push order.
- Lane A holding 2 words, assert rst for 1 cycle -> a_valid=0, a_cnt=0; the next push of 4'b0101 appears as the sole lane A word.
